alu_instr_sequencer: RTL and testbench

ALU_INSTR_SEQUENCER -- requirements
Module: alu_instr_sequencer

---
 rtl/alu_instr_sequencer_if.sv | 37 +++
 rtl/alu_instr_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_instr_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_instr_sequencer_if.sv
// alu_instr_sequencer_if
//   Bundles the instruction-load, run-control, ALU-control and result-read
//   signals of alu_instr_sequencer. clk and rst_n stay plain module ports.
//
//   master : driven by the environment (loader / ALU control unit / reader)
//     wr_en, wr_addr[3:0], wr_data[19:0]  instruction-memory write
//     count[4:0], start                   run request
//     result_in[7:0]                      combinational ALU result for instr
//     rd_addr[3:0]                        result-memory read address
//   slave  : the sequencer
//     instr[18:0], instr_valid            {opcode, op1, op2} to the ALU
//     rd_data[7:0]                        registered result read data
//     busy, done                          run status
interface alu_instr_sequencer_if;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [19:0] wr_data;
    logic [4:0]  count;
    logic        start;
    logic [18:0] instr;
    logic        instr_valid;
    logic [7:0]  result_in;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        done;

    modport master (
        output wr_en, wr_addr, wr_data, count, start, result_in, rd_addr,
        input  instr, instr_valid, rd_data, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, count, start, result_in, rd_addr,
        output instr, instr_valid, rd_data, busy, done
    );
endinterface

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer
//   Holds a small instruction memory and issues a run of instructions to an
//   ALU control unit, one per cycle, capturing each returned result into a
//   result memory. An instruction with its chain bit set takes its op1 from
//   the previous result of the same run (except at slot 0).
//
//   Ports:
//     clk    - single clock, rising edge
//     rst_n  - synchronous active-low reset (clears result memory, keeps
//              instruction memory)
//     bus    - alu_instr_sequencer_if.slave (see interface file)
//   Parameter:
//     DEPTH  - instruction/result slots (4-bit addressing, at most 16)
module alu_instr_sequencer #(
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_instr_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t      state;
    logic [19:0] imem [DEPTH];
    logic [7:0]  rmem [DEPTH];
    logic [3:0]  pc;
    logic [4:0]  run_len;
    logic [7:0]  prev_res;
    logic        valid_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  rd_q;

    logic [19:0] cur;
    logic [7:0]  op1_sel;
    logic [4:0]  cnt_clip;
    logic        last;

    always_comb begin
        cur      = imem[pc];
        // Chaining has no predecessor at slot 0, so the stored op1 is used.
        op1_sel  = (cur[19] && (pc != '0)) ? prev_res : cur[15:8];
        cnt_clip = (bus.count > 5'(DEPTH)) ? 5'(DEPTH) : bus.count;
        last     = ({1'b0, pc} == (run_len - 5'd1));
    end

    assign bus.instr       = valid_q ? {cur[18:16], op1_sel, cur[7:0]} : '0;
    assign bus.instr_valid = valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.rd_data     = rd_q;

    // Instruction memory is not reset; loads are accepted only while idle.
    // A load in the same cycle as start lands before the first issue cycle
    // reads it, so the run sees the new word.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (state == IDLE)) begin
            imem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            run_len  <= '0;
            prev_res <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rmem[i] <= '0;
            end
        end else begin
            // Read returns the pre-edge contents even if the slot is
            // written on this same edge.
            rd_q <= rmem[bus.rd_addr];

            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (bus.count != '0) begin
                            run_len <= cnt_clip;
                            pc      <= '0;
                            state   <= ISSUE;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    rmem[pc] <= bus.result_in;
                    prev_res <= bus.result_in;
                    pc       <= pc + 4'd1;
                    if (last) begin
                        state   <= DONE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer
//   Directed and randomized runs of alu_instr_sequencer against a reference
//   model of the instruction and result memories. The ALU control unit is a
//   small combinational function of the issued instr.
module tb_alu_instr_sequencer;

    logic clk;
    logic rst_n;

    alu_instr_sequencer_if bus ();

    alu_instr_sequencer #(.DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [19:0] imem_m [16];
    logic [7:0]  rmem_m [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return b;
            default: return a;
        endcase
    endfunction

    assign bus.result_in = alu_f(bus.instr[18:16], bus.instr[15:8], bus.instr[7:0]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [19:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
        imem_m[a]   = d;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_done"},  32'(bus.done), 32'd0);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        chk({tag, "_instr"}, 32'(bus.instr), 32'd0);
    endtask

    // Runs cnt instructions and checks every cycle against the model.
    // disturb pulses start and a load of slot 1 during ISSUE and DONE.
    task automatic do_run(input int cnt, input bit disturb);
        int          n;
        logic [18:0] exp_i [16];
        logic [7:0]  exp_r [16];
        logic [7:0]  prev;
        logic [7:0]  op1;
        logic [19:0] w;
        n    = (cnt > 16) ? 16 : cnt;
        prev = 8'd0;
        for (int i = 0; i < n; i++) begin
            w        = imem_m[i];
            op1      = (w[19] && i > 0) ? prev : w[15:8];
            exp_i[i] = {w[18:16], op1, w[7:0]};
            exp_r[i] = alu_f(w[18:16], op1, w[7:0]);
            prev     = exp_r[i];
        end

        bus.count = 5'(cnt);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;

        if (n == 0) begin
            chk("zero_done",  32'(bus.done), 32'd1);
            chk("zero_valid", 32'(bus.instr_valid), 32'd0);
            chk("zero_busy",  32'(bus.busy), 32'd0);
            tick();
            check_idle("zero_after");
        end else begin
            for (int k = 0; k < n; k++) begin
                chk("issue_valid", 32'(bus.instr_valid), 32'd1);
                chk("issue_busy",  32'(bus.busy), 32'd1);
                chk("issue_done",  32'(bus.done), 32'd0);
                chk("issue_instr", 32'(bus.instr), 32'(exp_i[k]));
                if (disturb && k == 1) begin
                    bus.start   = 1'b1;
                    bus.count   = 5'd2;
                    bus.wr_en   = 1'b1;
                    bus.wr_addr = 4'd1;
                    bus.wr_data = ~imem_m[1];
                end
                tick();
                bus.start = 1'b0;
                bus.wr_en = 1'b0;
            end
            chk("done_pulse", 32'(bus.done), 32'd1);
            chk("done_busy",  32'(bus.busy), 32'd0);
            chk("done_valid", 32'(bus.instr_valid), 32'd0);
            chk("done_instr", 32'(bus.instr), 32'd0);
            if (disturb) begin
                bus.start   = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_addr = 4'd1;
                bus.wr_data = ~imem_m[1];
            end
            tick();
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            check_idle("after_done");
            for (int i = 0; i < n; i++) rmem_m[i] = exp_r[i];
        end
    endtask

    task automatic readback(input string tag);
        for (int a = 0; a < 16; a++) begin
            bus.rd_addr = 4'(a);
            tick();
            chk(tag, 32'(bus.rd_data), 32'(rmem_m[a]));
        end
    endtask

    initial begin
        logic [19:0] rw;
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.count   = '0;
        bus.start   = 1'b0;
        bus.rd_addr = '0;
        for (int i = 0; i < 16; i++) rmem_m[i] = 8'd0;

        tick();
        tick();
        check_idle("reset");
        chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single add 5+3, loaded in the same cycle as start.
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd0;
        bus.wr_data = {1'b0, 3'b001, 8'd5, 8'd3};
        imem_m[0]   = bus.wr_data;
        bus.count   = 5'd1;
        bus.start   = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
        bus.start   = 1'b0;
        chk("single_instr", 32'(bus.instr), 32'h10503);
        chk("single_valid", 32'(bus.instr_valid), 32'd1);
        tick();
        chk("single_done", 32'(bus.done), 32'd1);
        rmem_m[0] = 8'd8;
        bus.rd_addr = 4'd0;
        tick();
        chk("single_rd", 32'(bus.rd_data), 32'd8);

        // Chained adds: 1+1, prev+2, prev+3.
        load(4'd0, {1'b0, 3'b001, 8'd1, 8'd1});
        load(4'd1, {1'b1, 3'b001, 8'd99, 8'd2});
        load(4'd2, {1'b1, 3'b001, 8'd77, 8'd3});
        do_run(3, 1'b0);
        chk("chain_r0", 32'(rmem_m[0]), 32'd2);
        chk("chain_r1", 32'(rmem_m[1]), 32'd4);
        chk("chain_r2", 32'(rmem_m[2]), 32'd7);
        readback("chain_rd");

        // Slot 0 with chain set uses its stored op1.
        load(4'd0, {1'b1, 3'b001, 8'd10, 8'd20});
        do_run(1, 1'b0);

        // Zero-length run.
        do_run(0, 1'b0);

        // Full memory, over-long count.
        for (int i = 0; i < 16; i++) begin
            rw = 20'($urandom);
            load(4'(i), rw);
        end
        do_run(20, 1'b0);
        readback("full_rd");

        // start / load during ISSUE and DONE are ignored; rerun is normal.
        do_run(4, 1'b1);
        do_run(4, 1'b0);
        readback("disturb_rd");

        // Reset in the second ISSUE cycle of a 4-instruction run.
        bus.count = 5'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("abort_pre_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle("abort");
        for (int i = 0; i < 16; i++) rmem_m[i] = 8'd0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("abort_no_done", 32'(bus.done), 32'd0);
        end
        readback("abort_rd");
        do_run(4, 1'b0);
        readback("rerun_rd");

        // Randomized loads and run lengths.
        for (int r = 0; r < 8; r++) begin
            int nl;
            nl = int'($urandom_range(0, 6));
            for (int j = 0; j < nl; j++) begin
                rw = 20'($urandom);
                load(4'($urandom_range(0, 15)), rw);
            end
            do_run(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
            bus.rd_addr = 4'($urandom_range(0, 15));
            tick();
            chk("rand_rd", 32'(bus.rd_data), 32'(rmem_m[bus.rd_addr]));
        end
        readback("final_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
